// File: rtl/laser_driver_if.sv
// Bus between the laser_driver and the host/core side: image write port,
// run control, point stream to the core, core results and the result report.
// The slave modport is the driver; the master modport is the host/core side.
interface laser_driver_if;
   logic       WE;
   logic [5:0] WADDR;
   logic [3:0] WX;
   logic [3:0] WY;
   logic       START;
   logic       BUSY;
   logic       LRST;
   logic [3:0] X;
   logic [3:0] Y;
   logic       DONE;
   logic [3:0] C1X;
   logic [3:0] C1Y;
   logic [3:0] C2X;
   logic [3:0] C2Y;
   logic       RES_VALID;
   logic [3:0] R1X;
   logic [3:0] R1Y;
   logic [3:0] R2X;
   logic [3:0] R2Y;
   logic [5:0] SCORE;
   logic       TIMEOUT;

   modport slave (
      input  WE, WADDR, WX, WY, START, DONE, C1X, C1Y, C2X, C2Y,
      output BUSY, LRST, X, Y, RES_VALID, R1X, R1Y, R2X, R2Y, SCORE, TIMEOUT
   );

   modport master (
      output WE, WADDR, WX, WY, START, DONE, C1X, C1Y, C2X, C2Y,
      input  BUSY, LRST, X, Y, RES_VALID, R1X, R1Y, R2X, R2Y, SCORE, TIMEOUT
   );
endinterface

// File: rtl/laser_driver.sv
// Host-side driver for the laser circle-placement core. Holds an NPTS-point
// target image, resets the core, streams the image, waits for the core's
// DONE, captures both centres and scores how many targets either circle
// covers, then emits a one-cycle report.
// Optional build macro DRV_TIMEOUT_EN: adds a WAIT watchdog of TO_CYCLES
// cycles that aborts the run with TIMEOUT=1 and SCORE=0.
module laser_driver #(
   parameter int NPTS      = 40,
   parameter int RADIUS_SQ = 16
`ifdef DRV_TIMEOUT_EN
   ,parameter int TO_CYCLES = 65535
`endif
) (
   input  logic          CLK,
   input  logic          RST,
   laser_driver_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_PULSE, S_GAP, S_FEED, S_WAIT, S_SCORE, S_REPORT
   } state_t;

   state_t     state;
   logic [7:0] image [NPTS];
   logic [5:0] idx;
   logic [5:0] idx_nxt;
   logic       arm;
   logic [5:0] acc;
   logic       hit_p1;
   logic       vld_p1;
`ifdef DRV_TIMEOUT_EN
   logic [15:0] to_cnt;
`endif

   assign idx_nxt = idx + 6'd1;

   function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
      logic signed [4:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[4] ? 4'(-d) : d[3:0];
   endfunction

   function automatic logic covered(input logic [3:0] px, input logic [3:0] py,
                                    input logic [3:0] cx, input logic [3:0] cy);
      logic [3:0] ax;
      logic [3:0] ay;
      logic [7:0] sx;
      logic [7:0] sy;
      logic [8:0] d2;
      ax = abs_diff(px, cx);
      ay = abs_diff(py, cy);
      sx = {4'd0, ax} * {4'd0, ax};
      sy = {4'd0, ay} * {4'd0, ay};
      d2 = {1'b0, sx} + {1'b0, sy};
      return d2 <= 9'(RADIUS_SQ);
   endfunction

   // Image store: host writes land only while idle and inside the image.
   always_ff @(posedge CLK) begin
      if (bus.WE && state == S_IDLE && bus.WADDR < 6'(NPTS))
         image[bus.WADDR] <= {bus.WX, bus.WY};
   end

   // Score stage p1: coverage of the point under idx by either captured centre.
   always_ff @(posedge CLK) begin
      hit_p1 <= covered(image[idx][7:4], image[idx][3:0], bus.R1X, bus.R1Y) |
                covered(image[idx][7:4], image[idx][3:0], bus.R2X, bus.R2Y);
   end

   // Run sequencer with registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state         <= S_IDLE;
         bus.BUSY      <= 1'b0;
         bus.LRST      <= 1'b0;
         bus.X         <= 4'd0;
         bus.Y         <= 4'd0;
         bus.RES_VALID <= 1'b0;
         bus.R1X       <= 4'd0;
         bus.R1Y       <= 4'd0;
         bus.R2X       <= 4'd0;
         bus.R2Y       <= 4'd0;
         bus.SCORE     <= 6'd0;
         idx           <= 6'd0;
         arm           <= 1'b0;
         acc           <= 6'd0;
         vld_p1        <= 1'b0;
`ifdef DRV_TIMEOUT_EN
         to_cnt        <= 16'd0;
         bus.TIMEOUT   <= 1'b0;
`endif
      end else begin
         vld_p1 <= (state == S_SCORE);
         case (state)
            S_IDLE: begin
               if (bus.START) begin
                  state    <= S_PULSE;
                  bus.BUSY <= 1'b1;
                  bus.LRST <= 1'b1;
               end
            end
            S_PULSE: begin
               bus.LRST <= 1'b0;
               state    <= S_GAP;
            end
            S_GAP: begin
               idx   <= 6'd0;
               arm   <= 1'b0;
               bus.X <= image[0][7:4];
               bus.Y <= image[0][3:0];
               state <= S_FEED;
            end
            S_FEED: begin
               if (!bus.DONE)
                  arm <= 1'b1;
               if (idx == 6'(NPTS - 1)) begin
                  bus.X <= 4'd0;
                  bus.Y <= 4'd0;
                  idx   <= 6'd0;
                  state <= S_WAIT;
`ifdef DRV_TIMEOUT_EN
                  to_cnt <= 16'd0;
`endif
               end else begin
                  idx   <= idx_nxt;
                  bus.X <= image[idx_nxt][7:4];
                  bus.Y <= image[idx_nxt][3:0];
               end
            end
            S_WAIT: begin
               // A DONE left high from before the core reset must drop once
               // before it can count as this run's completion.
               if (bus.DONE && arm) begin
                  bus.R1X <= bus.C1X;
                  bus.R1Y <= bus.C1Y;
                  bus.R2X <= bus.C2X;
                  bus.R2Y <= bus.C2Y;
                  idx     <= 6'd0;
                  acc     <= 6'd0;
                  state   <= S_SCORE;
               end else begin
                  if (!bus.DONE)
                     arm <= 1'b1;
`ifdef DRV_TIMEOUT_EN
                  if (to_cnt == 16'(TO_CYCLES - 1)) begin
                     bus.SCORE     <= 6'd0;
                     bus.RES_VALID <= 1'b1;
                     bus.TIMEOUT   <= 1'b1;
                     state         <= S_REPORT;
                  end else begin
                     to_cnt <= to_cnt + 16'd1;
                  end
`endif
               end
            end
            S_SCORE: begin
               if (vld_p1)
                  acc <= acc + 6'(hit_p1);
               if (idx == 6'(NPTS - 1))
                  state <= S_REPORT;
               else
                  idx <= idx_nxt;
            end
            S_REPORT: begin
               // First cycle folds in the last point still in the score
               // stage; the second cycle presents the report.
               if (!bus.RES_VALID) begin
                  bus.SCORE     <= acc + 6'(hit_p1);
                  bus.RES_VALID <= 1'b1;
               end else begin
                  bus.RES_VALID <= 1'b0;
                  bus.BUSY      <= 1'b0;
                  state         <= S_IDLE;
`ifdef DRV_TIMEOUT_EN
                  bus.TIMEOUT   <= 1'b0;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifndef DRV_TIMEOUT_EN
   assign bus.TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_laser_driver.sv
// Bench for laser_driver: table of image/centre cases with known scores,
// randomized runs scored by a plain-arithmetic model, and hand sequences for
// early DONE, reset mid-stream, writes/START while busy and the watchdog.
module tb_laser_driver;
   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   laser_driver_if bus_if ();

`ifdef DRV_TIMEOUT_EN
   laser_driver #(.TO_CYCLES(100)) dut (.CLK(CLK), .RST(RST), .bus(bus_if));
`else
   laser_driver dut (.CLK(CLK), .RST(RST), .bus(bus_if));
`endif

   typedef struct {
      int pat;
      int c1x, c1y, c2x, c2y;
      int exp_score;
      bit early;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int img_x [40];
   int img_y [40];
   int rx1 = 0, ry1 = 0, rx2 = 0, ry2 = 0;
   vec_t tbl [5];

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   function automatic int ref_score(input int c1x, input int c1y, input int c2x, input int c2y);
      int n = 0;
      for (int i = 0; i < 40; i++) begin
         int a1 = (img_x[i] - c1x) * (img_x[i] - c1x) + (img_y[i] - c1y) * (img_y[i] - c1y);
         int a2 = (img_x[i] - c2x) * (img_x[i] - c2x) + (img_y[i] - c2y) * (img_y[i] - c2y);
         if (a1 <= 16 || a2 <= 16) n++;
      end
      return n;
   endfunction

   task automatic load(input int pat);
      for (int i = 0; i < 40; i++) begin
         case (pat)
            0: begin img_x[i] = i % 16; img_y[i] = i / 16; end
            1: begin img_x[i] = (i < 20) ? 3 : 0; img_y[i] = (i < 20) ? 3 : 0; end
            2: begin
               case (i)
                  0: begin img_x[i] = 7;  img_y[i] = 3; end
                  1: begin img_x[i] = 7;  img_y[i] = 4; end
                  2: begin img_x[i] = 3;  img_y[i] = 3; end
                  default: begin img_x[i] = 15; img_y[i] = 0; end
               endcase
            end
            default: begin
               img_x[i] = int'($urandom_range(15));
               img_y[i] = int'($urandom_range(15));
            end
         endcase
         bus_if.WE    = 1'b1;
         bus_if.WADDR = 6'(i);
         bus_if.WX    = 4'(img_x[i]);
         bus_if.WY    = 4'(img_y[i]);
         @(negedge CLK);
      end
      for (int k = 0; k < 4; k++) begin
         bus_if.WADDR = 6'(40 + $urandom_range(23));
         bus_if.WX    = 4'($urandom_range(15));
         bus_if.WY    = 4'($urandom_range(15));
         @(negedge CLK);
      end
      bus_if.WE = 1'b0;
   endtask

   function automatic int r_errs();
      return (int'(bus_if.R1X) != rx1 || int'(bus_if.R1Y) != ry1 ||
              int'(bus_if.R2X) != rx2 || int'(bus_if.R2Y) != ry2) ? 1 : 0;
   endfunction

   task automatic run(input int c1x, input int c1y, input int c2x, input int c2y,
                      input int exp_score, input bit early, input string tag);
      int errs;
      int gap;
      gap = 5 + int'($urandom_range(15));
      bus_if.DONE = early;
      bus_if.C1X = 4'(c1x ^ 10); bus_if.C1Y = 4'(c1y ^ 10);
      bus_if.C2X = 4'(c2x ^ 10); bus_if.C2Y = 4'(c2y ^ 10);
      bus_if.START = 1'b1;
      @(negedge CLK);
      bus_if.START = 1'b0;
      check({tag, ".lrst_pulse"}, int'(bus_if.LRST), 1);
      check({tag, ".busy"}, int'(bus_if.BUSY), 1);
      @(negedge CLK);
      check({tag, ".gap_lrst_xy"}, int'({bus_if.LRST, bus_if.X, bus_if.Y}), 0);
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (int'(bus_if.X) != img_x[i] || int'(bus_if.Y) != img_y[i] ||
             bus_if.LRST || !bus_if.BUSY) errs++;
      end
      check({tag, ".stream_errs"}, errs, 0);
      errs = 0;
      for (int k = 0; k < gap; k++) begin
         @(negedge CLK);
         if (bus_if.RES_VALID || bus_if.LRST || bus_if.X != 4'd0 || bus_if.Y != 4'd0 ||
             !bus_if.BUSY) errs++;
         errs += r_errs();
         bus_if.DONE  = early && (k < 2);
         bus_if.WE    = (k == 1);
         bus_if.WADDR = 6'($urandom_range(39));
         bus_if.WX    = 4'($urandom_range(15));
         bus_if.WY    = 4'($urandom_range(15));
         bus_if.START = (k == 2);
      end
      check({tag, ".wait_errs"}, errs, 0);
      @(negedge CLK);
      check({tag, ".no_early_capture"}, r_errs(), 0);
      bus_if.WE = 1'b0; bus_if.START = 1'b0;
      bus_if.DONE = 1'b1;
      bus_if.C1X = 4'(c1x); bus_if.C1Y = 4'(c1y);
      bus_if.C2X = 4'(c2x); bus_if.C2Y = 4'(c2y);
      @(negedge CLK);
      check({tag, ".r1x"}, int'(bus_if.R1X), c1x);
      check({tag, ".r1y"}, int'(bus_if.R1Y), c1y);
      check({tag, ".r2x"}, int'(bus_if.R2X), c2x);
      check({tag, ".r2y"}, int'(bus_if.R2Y), c2y);
      rx1 = c1x; ry1 = c1y; rx2 = c2x; ry2 = c2y;
      bus_if.C1X = 4'(c1x ^ 5); bus_if.C1Y = 4'(c1y ^ 5);
      bus_if.C2X = 4'(c2x ^ 5); bus_if.C2Y = 4'(c2y ^ 5);
      bus_if.DONE = 1'($urandom_range(1));
      errs = 0;
      for (int j = 2; j <= 41; j++) begin
         @(negedge CLK);
         if (bus_if.RES_VALID || !bus_if.BUSY) errs++;
      end
      check({tag, ".score_phase_errs"}, errs, 0);
      @(negedge CLK);
      check({tag, ".res_valid"}, int'(bus_if.RES_VALID), 1);
      check({tag, ".score"}, int'(bus_if.SCORE), exp_score);
      check({tag, ".timeout"}, int'(bus_if.TIMEOUT), 0);
      check({tag, ".report_busy"}, int'(bus_if.BUSY), 1);
      check({tag, ".r_held"}, r_errs(), 0);
      bus_if.START = 1'b1;
      bus_if.DONE  = 1'b0;
      @(negedge CLK);
      bus_if.START = 1'b0;
      check({tag, ".rv_one_cycle"}, int'(bus_if.RES_VALID), 0);
      check({tag, ".idle_busy"}, int'(bus_if.BUSY), 0);
      check({tag, ".start_ignored"}, int'(bus_if.LRST), 0);
      check({tag, ".score_held"}, int'(bus_if.SCORE), exp_score);
      @(negedge CLK);
      check({tag, ".still_idle"}, int'({bus_if.LRST, bus_if.BUSY}), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".busy"}, int'(bus_if.BUSY), 0);
      check({tag, ".lrst"}, int'(bus_if.LRST), 0);
      check({tag, ".xy"}, int'({bus_if.X, bus_if.Y}), 0);
      check({tag, ".res_valid"}, int'(bus_if.RES_VALID), 0);
      check({tag, ".r1"}, int'({bus_if.R1X, bus_if.R1Y}), 0);
      check({tag, ".r2"}, int'({bus_if.R2X, bus_if.R2Y}), 0);
      check({tag, ".score"}, int'(bus_if.SCORE), 0);
      check({tag, ".timeout"}, int'(bus_if.TIMEOUT), 0);
   endtask

   initial begin
      int cur;
      int a, b, c, d;
      bus_if.WE = 1'b0; bus_if.WADDR = 6'd0; bus_if.WX = 4'd0; bus_if.WY = 4'd0;
      bus_if.START = 1'b0; bus_if.DONE = 1'b0;
      bus_if.C1X = 4'd0; bus_if.C1Y = 4'd0; bus_if.C2X = 4'd0; bus_if.C2Y = 4'd0;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check_reset_vals("reset");
      RST = 1'b0;
      @(negedge CLK);

      load(0);
      run(0, 0, 8, 1, ref_score(0, 0, 8, 1), 1'b0, "ramp");

      tbl[0] = '{1, 3, 3, 12, 12, 20, 1'b0};
      tbl[1] = '{1, 3, 3, 12, 12, 20, 1'b1};
      tbl[2] = '{1, 0, 0, 3, 3, 40, 1'b0};
      tbl[3] = '{2, 3, 3, 12, 12, 2, 1'b0};
      tbl[4] = '{2, 3, 3, 5, 3, 3, 1'b1};
      cur = -1;
      for (int v = 0; v < 5; v++) begin
         if (tbl[v].pat != cur) begin
            load(tbl[v].pat);
            cur = tbl[v].pat;
         end
         run(tbl[v].c1x, tbl[v].c1y, tbl[v].c2x, tbl[v].c2y, tbl[v].exp_score,
             tbl[v].early, $sformatf("tbl%0d", v));
      end

      for (int r = 0; r < 4; r++) begin
         load(3);
         for (int s = 0; s < 2; s++) begin
            a = int'($urandom_range(15)); b = int'($urandom_range(15));
            c = int'($urandom_range(15)); d = int'($urandom_range(15));
            run(a, b, c, d, ref_score(a, b, c, d), 1'($urandom_range(1)),
                $sformatf("rand%0d_%0d", r, s));
         end
      end

      bus_if.START = 1'b1;
      @(negedge CLK);
      bus_if.START = 1'b0;
      repeat (19) @(negedge CLK);
      check("midfeed.point17", int'({bus_if.X, bus_if.Y}), img_x[17] * 16 + img_y[17]);
      RST = 1'b1;
      @(negedge CLK);
      check_reset_vals("midfeed_rst");
      RST = 1'b0;
      rx1 = 0; ry1 = 0; rx2 = 0; ry2 = 0;
      @(negedge CLK);
      check("midfeed.idle", int'({bus_if.BUSY, bus_if.LRST}), 0);
      run(3, 3, 12, 12, ref_score(3, 3, 12, 12), 1'b0, "post_rst");

`ifdef DRV_TIMEOUT_EN
      begin
         int errs;
         bus_if.DONE = 1'b0;
         bus_if.START = 1'b1;
         @(negedge CLK);
         bus_if.START = 1'b0;
         errs = int'(bus_if.RES_VALID);
         for (int n = 2; n <= 142; n++) begin
            @(negedge CLK);
            errs += int'(bus_if.RES_VALID);
         end
         check("to.early_rv", errs, 0);
         @(negedge CLK);
         check("to.res_valid", int'(bus_if.RES_VALID), 1);
         check("to.timeout", int'(bus_if.TIMEOUT), 1);
         check("to.score", int'(bus_if.SCORE), 0);
         check("to.r_unchanged", r_errs(), 0);
         @(negedge CLK);
         check("to.after", int'({bus_if.RES_VALID, bus_if.TIMEOUT, bus_if.BUSY}), 0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
